rf_arbiter: RTL and testbench
=============================

RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the register data width.
REQ-002 Parameter REGBITS, default 4, SHALL set the register address width (16 registers).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 core_wr_req / core_wr_addr / core_wr_data  input  1/REGBITS/WIDTH  datapath write-back request.
REQ-006 core_wr_gnt  output  1  core write committed at this clock edge.
REQ-007 core_src_addr / core_dst_addr  input  REGBITS each  datapath read addresses.
REQ-008 core_stall  output  1  datapath SHALL hold state while high.
REQ-009 dbg_req / dbg_we / dbg_addr / dbg_wdata  input  1/1/REGBITS/WIDTH  debug-port access.
REQ-010 dbg_gnt  output  1  debug access accepted this cycle.
REQ-011 dbg_rdata / dbg_rvalid  output  WIDTH/1  debug read data, valid one cycle after the read grant.
REQ-012 init_busy  output  1  register clear in progress.
REQ-013 rf_regWrite / rf_destAddr / rf_sourceAddr / rf_wrData  output  1/REGBITS/REGBITS/WIDTH  register-file control.
REQ-014 rf_readData2  input  WIDTH  register-file read port indexed by rf_sourceAddr.

Function
REQ-015 FSM states: INIT, RUN.
- INIT: entered on reset; 4-bit clear counter cnt starts at 0.
- Each INIT cycle: rf_regWrite=1, rf_destAddr=cnt, rf_wrData=0; cnt increments.
- INIT->RUN after cnt=15 is written (exactly 16 cycles).
REQ-016 In INIT, init_busy=1, core_stall=1, and all grants SHALL be 0.
REQ-017 RUN, write requests only: the requesting writer SHALL be granted in the same cycle (combinational gnt), and the write SHALL commit at the next edge.
REQ-018 RUN, simultaneous core write and debug write: 2-way round-robin.
- Grant goes to the requester not granted at the last contention.
- The pointer resets to favour core.
- The pointer updates only on contention cycles.
REQ-019 The losing writer receives no grant and SHALL hold its request; a held request is never dropped.
REQ-020 Writes to address 0 SHALL be granted but drive rf_regWrite=0.
REQ-021 Debug read (dbg_req=1, dbg_we=0) in RUN:
- Always granted immediately.
- rf_sourceAddr=dbg_addr; rf_readData2 captured into dbg_rdata at the edge.
- dbg_rvalid=1 for exactly the following cycle.
REQ-022 A debug read SHALL NOT block a concurrent core write (separate ports).
REQ-023 core_stall SHALL be 1 in any cycle in which dbg_gnt=1 (read or write), else 0 in RUN.
REQ-024 rf_sourceAddr SHALL equal core_src_addr except during a debug-read grant.
REQ-025 rf_destAddr SHALL be the granted writer's address, else core_dst_addr.
REQ-026 rf_wrData SHALL be the granted writer's data, else 0.
REQ-027 A debug write granted on contention SHALL leave core_wr_gnt=0 and core_stall=1 for that cycle.

Reset
REQ-028 reset low SHALL asynchronously force:
- state=INIT, cnt=0, rr pointer=core;
- dbg_rdata=0, dbg_rvalid=0, all grants 0.
REQ-029 Reset asserted mid-clear or mid-access SHALL abort it; clearing restarts from register 0 after release.

Structure
REQ-030 Shared package rf_arb_pkg SHALL hold the state enum and the WIDTH/REGBITS defaults.
REQ-031 Round-robin selection SHALL live in sub-module rf_rr_arb2 (2 requests, 2 one-hot grants, pointer flop).

Verification
REQ-032 Release reset -> 16 cycles with rf_regWrite=1 and rf_destAddr 0..15, data 0; init_busy falls on cycle 17.
REQ-033 RUN, core_wr_req with addr 3, data 0x1234 -> core_wr_gnt=1 same cycle; a later debug read of reg 3 returns 0x1234 with dbg_rvalid one cycle after grant.
REQ-034 Both writers held high for 4 cycles (core addr 5, dbg addr 6) -> grants alternate core, dbg, core, dbg.
REQ-035 Debug read of reg 7 concurrent with core write to reg 2 -> both granted, core_stall=1, rf_sourceAddr=7.
REQ-036 Core write to addr 0 -> core_wr_gnt=1 with rf_regWrite=0.
REQ-037 Assert reset at INIT cycle 8 -> outputs clear immediately; after release, clearing restarts at register 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared state encoding and parameter defaults for the register-file arbiter
package rf_arb_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REGBITS = 4;

    // INIT clears every register once after reset; RUN arbitrates core and debug traffic.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_arb_state_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// rtl/rf_rr_arb2.sv - two-way round-robin arbiter with a single priority flop
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   req[1:0]    : bit 0 = core writer, bit 1 = debug writer
//   gnt[1:0]    : one-hot grant, combinational from req and the priority flop
module rf_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio_q = 0 favours the core, 1 favours debug. Only moves on contention,
    // so an uncontested requester never disturbs the fairness history.
    logic prio_q;
    logic prio_d;

    always_comb begin
        prio_d = prio_q;
        gnt    = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt    = prio_q ? 2'b10 : 2'b01;
                prio_d = ~prio_q;
            end
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rf_arbiter.sv
// rtl/rf_arbiter.sv - register-file port arbiter between datapath write-back and a debug port
//
// Ports:
//   clk, reset                          : clock, asynchronous active-low reset
//   core_wr_req/addr/data, core_wr_gnt  : datapath write-back request and same-cycle grant
//   core_src_addr, core_dst_addr        : datapath read/destination addresses
//   core_stall                          : datapath must hold while high
//   dbg_req/we/addr/wdata, dbg_gnt      : debug access and its grant
//   dbg_rdata, dbg_rvalid               : debug read data, valid the cycle after a read grant
//   init_busy                           : post-reset register clear in progress
//   rf_regWrite/destAddr/sourceAddr/wrData, rf_readData2 : register-file control and read data
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               core_wr_req,
    input  logic [REGBITS-1:0] core_wr_addr,
    input  logic [WIDTH-1:0]   core_wr_data,
    output logic               core_wr_gnt,
    input  logic [REGBITS-1:0] core_src_addr,
    input  logic [REGBITS-1:0] core_dst_addr,
    output logic               core_stall,
    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [REGBITS-1:0] dbg_addr,
    input  logic [WIDTH-1:0]   dbg_wdata,
    output logic               dbg_gnt,
    output logic [WIDTH-1:0]   dbg_rdata,
    output logic               dbg_rvalid,
    output logic               init_busy,
    output logic               rf_regWrite,
    output logic [REGBITS-1:0] rf_destAddr,
    output logic [REGBITS-1:0] rf_sourceAddr,
    output logic [WIDTH-1:0]   rf_wrData,
    input  logic [WIDTH-1:0]   rf_readData2
);

    rf_arb_state_t      state_q, state_d;
    logic [REGBITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic               dbg_rvalid_q, dbg_rvalid_d;

    logic               run;
    logic [1:0]         wr_req;
    logic [1:0]         wr_gnt;
    logic               dbg_rd;

    assign run = (state_q == ST_RUN);

    // Requests are masked in INIT so the round-robin pointer cannot move while clearing.
    assign wr_req = {run & dbg_req & dbg_we, run & core_wr_req};

    rf_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dbg_rdata_d   = dbg_rdata_q;
        dbg_rvalid_d  = 1'b0;
        dbg_rd        = 1'b0;
        core_wr_gnt   = 1'b0;
        dbg_gnt       = 1'b0;
        core_stall    = 1'b0;
        init_busy     = 1'b0;
        rf_regWrite   = 1'b0;
        rf_destAddr   = core_dst_addr;
        rf_sourceAddr = core_src_addr;
        rf_wrData     = '0;

        case (state_q)
            ST_INIT: begin
                init_busy   = 1'b1;
                core_stall  = 1'b1;
                rf_regWrite = 1'b1;
                rf_destAddr = cnt_q;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == {REGBITS{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Debug reads use the second read port, so they never compete with writes.
                dbg_rd      = dbg_req & ~dbg_we;
                core_wr_gnt = wr_gnt[0];
                dbg_gnt     = wr_gnt[1] | dbg_rd;
                core_stall  = wr_gnt[1] | dbg_rd;

                if (wr_gnt[1]) begin
                    rf_destAddr = dbg_addr;
                    rf_wrData   = dbg_wdata;
                    rf_regWrite = (dbg_addr != '0);
                end else if (wr_gnt[0]) begin
                    rf_destAddr = core_wr_addr;
                    rf_wrData   = core_wr_data;
                    rf_regWrite = (core_wr_addr != '0);
                end

                if (dbg_rd) begin
                    rf_sourceAddr = dbg_addr;
                    dbg_rdata_d   = rf_readData2;
                    dbg_rvalid_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_rf_arbiter.sv
// tb/tb_rf_arbiter.sv - self-checking bench for rf_arbiter against a behavioural model
module tb_rf_arbiter;

    localparam int W  = 16;
    localparam int RB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_wr_req;
    logic [RB-1:0] core_wr_addr;
    logic [W-1:0]  core_wr_data;
    logic          core_wr_gnt;
    logic [RB-1:0] core_src_addr;
    logic [RB-1:0] core_dst_addr;
    logic          core_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [RB-1:0] dbg_addr;
    logic [W-1:0]  dbg_wdata;
    logic          dbg_gnt;
    logic [W-1:0]  dbg_rdata;
    logic          dbg_rvalid;
    logic          init_busy;
    logic          rf_regWrite;
    logic [RB-1:0] rf_destAddr;
    logic [RB-1:0] rf_sourceAddr;
    logic [W-1:0]  rf_wrData;
    logic [W-1:0]  rf_readData2;

    always #5 clk = ~clk;

    rf_arbiter #(.WIDTH(W), .REGBITS(RB)) dut (
        .clk           (clk),
        .reset         (reset),
        .core_wr_req   (core_wr_req),
        .core_wr_addr  (core_wr_addr),
        .core_wr_data  (core_wr_data),
        .core_wr_gnt   (core_wr_gnt),
        .core_src_addr (core_src_addr),
        .core_dst_addr (core_dst_addr),
        .core_stall    (core_stall),
        .dbg_req       (dbg_req),
        .dbg_we        (dbg_we),
        .dbg_addr      (dbg_addr),
        .dbg_wdata     (dbg_wdata),
        .dbg_gnt       (dbg_gnt),
        .dbg_rdata     (dbg_rdata),
        .dbg_rvalid    (dbg_rvalid),
        .init_busy     (init_busy),
        .rf_regWrite   (rf_regWrite),
        .rf_destAddr   (rf_destAddr),
        .rf_sourceAddr (rf_sourceAddr),
        .rf_wrData     (rf_wrData),
        .rf_readData2  (rf_readData2)
    );

    // Register file driven by the DUT's control outputs.
    logic [W-1:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_regWrite) rf_mem[rf_destAddr] <= rf_wrData;
    end
    assign rf_readData2 = rf_mem[rf_sourceAddr];

    // Reference model: register contents, who wins the next contention, pending read result.
    logic [W-1:0] m_regs [16];
    bit           m_core_next;
    bit           m_rvalid;
    logic [W-1:0] m_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_idle();
        core_wr_req   = 1'b0;
        core_wr_addr  = '0;
        core_wr_data  = '0;
        core_src_addr = '0;
        core_dst_addr = '0;
        dbg_req       = 1'b0;
        dbg_we        = 1'b0;
        dbg_addr      = '0;
        dbg_wdata     = '0;
    endtask

    task automatic model_reset();
        m_core_next = 1'b1;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
    endtask

    // Reset must already be low; it is released at the first falling edge.
    // abort_at < 16 re-asserts reset during that clear cycle and returns.
    task automatic init_phase(input int abort_at);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) reset = 1'b1;
            core_wr_req   = 1'($urandom);
            core_wr_addr  = 4'($urandom);
            core_wr_data  = 16'($urandom);
            dbg_req       = 1'($urandom);
            dbg_we        = 1'($urandom);
            dbg_addr      = 4'($urandom);
            core_src_addr = 4'($urandom);
            core_dst_addr = 4'($urandom);
            #2;
            check_eq("init_busy", init_busy, 1);
            check_eq("init_we", rf_regWrite, 1);
            check_eq("init_dst", rf_destAddr, i);
            check_eq("init_wdata", rf_wrData, 0);
            check_eq("init_stall", core_stall, 1);
            check_eq("init_core_gnt", core_wr_gnt, 0);
            check_eq("init_dbg_gnt", dbg_gnt, 0);
            check_eq("init_rvalid", dbg_rvalid, 0);
            if (i == abort_at) begin
                reset = 1'b0;
                model_reset();
                #1;
                check_eq("abort_busy", init_busy, 1);
                check_eq("abort_dst", rf_destAddr, 0);
                check_eq("abort_core_gnt", core_wr_gnt, 0);
                check_eq("abort_dbg_gnt", dbg_gnt, 0);
                check_eq("abort_rvalid", dbg_rvalid, 0);
                return;
            end
        end
        @(negedge clk);
        drive_idle();
        #2;
        check_eq("run_busy", init_busy, 0);
        check_eq("run_stall", core_stall, 0);
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
    endtask

    // One RUN cycle: drive, check every output against the model, advance the model.
    task automatic run_cycle(input bit cw, input logic [RB-1:0] ca, input logic [W-1:0] cd,
                             input bit dq, input bit dwe, input logic [RB-1:0] da,
                             input logic [W-1:0] dd, output bit g_core, output bit g_dbg);
        bit            dw, dr, e_cg, e_dwg, e_we;
        logic [RB-1:0] e_dst;
        logic [W-1:0]  e_wd;
        @(negedge clk);
        core_wr_req   = cw;
        core_wr_addr  = ca;
        core_wr_data  = cd;
        dbg_req       = dq;
        dbg_we        = dwe;
        dbg_addr      = da;
        dbg_wdata     = dd;
        core_src_addr = 4'($urandom);
        core_dst_addr = 4'($urandom);
        #2;
        check_eq("rvalid", dbg_rvalid, m_rvalid);
        if (m_rvalid) check_eq("rdata", dbg_rdata, m_rdata);

        dw = dq && dwe;
        dr = dq && !dwe;
        if (cw && dw) begin
            e_cg        = m_core_next;
            e_dwg       = !m_core_next;
            m_core_next = e_dwg;   // the loser is favoured next time
        end else begin
            e_cg  = cw;
            e_dwg = dw;
        end
        e_dst = e_dwg ? da : (e_cg ? ca : core_dst_addr);
        e_wd  = e_dwg ? dd : (e_cg ? cd : '0);
        e_we  = (e_dwg || e_cg) && (e_dst != 0);

        check_eq("core_gnt", core_wr_gnt, e_cg);
        check_eq("dbg_gnt", dbg_gnt, e_dwg || dr);
        check_eq("stall", core_stall, e_dwg || dr);
        check_eq("rf_we", rf_regWrite, e_we);
        check_eq("rf_dst", rf_destAddr, e_dst);
        check_eq("rf_wdata", rf_wrData, e_wd);
        check_eq("rf_src", rf_sourceAddr, dr ? da : core_src_addr);
        check_eq("busy", init_busy, 0);

        m_rvalid = dr;
        if (dr) m_rdata = m_regs[da];
        if (e_we) m_regs[e_dst] = e_wd;
        g_core = e_cg;
        g_dbg  = e_dwg || dr;
    endtask

    bit            gc, gd;
    bit            pc_v, pd_v, pd_we;
    logic [RB-1:0] pc_a, pd_a;
    logic [W-1:0]  pc_d, pd_d;

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_rvalid", dbg_rvalid, 0);
        check_eq("rst_rdata", dbg_rdata, 0);
        check_eq("rst_core_gnt", core_wr_gnt, 0);
        check_eq("rst_dbg_gnt", dbg_gnt, 0);

        // Clear aborted during its 8th cycle, then a full clear from register 0.
        init_phase(7);
        repeat (2) @(negedge clk);
        init_phase(99);

        // Core write then debug read-back.
        run_cycle(1, 4'd3, 16'h1234, 0, 0, 4'd0, 16'h0, gc, gd);
        check_eq("wr3_gnt", core_wr_gnt, 1);
        run_cycle(0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, gc, gd);
        run_cycle(0, 4'd0, 16'h0, 1, 0, 4'd3, 16'h0, gc, gd);
        check_eq("rd3_gnt", dbg_gnt, 1);
        run_cycle(0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, gc, gd);
        check_eq("rd3_rvalid", dbg_rvalid, 1);
        check_eq("rd3_rdata", dbg_rdata, 16'h1234);

        // Both writers held for four cycles: core, dbg, core, dbg.
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 4'd5, 16'hA000 + 16'(i), 1, 1, 4'd6, 16'hB000 + 16'(i), gc, gd);
            check_eq("alt_core", core_wr_gnt, (i % 2) == 0);
            check_eq("alt_dbg", dbg_gnt, (i % 2) == 1);
        end

        // Debug read concurrent with core write.
        run_cycle(1, 4'd2, 16'h2222, 1, 0, 4'd7, 16'h0, gc, gd);
        check_eq("rdwr_core_gnt", core_wr_gnt, 1);
        check_eq("rdwr_dbg_gnt", dbg_gnt, 1);
        check_eq("rdwr_stall", core_stall, 1);
        check_eq("rdwr_src", rf_sourceAddr, 7);

        // Write to register 0 is granted but suppressed.
        run_cycle(1, 4'd0, 16'hBEEF, 0, 0, 4'd0, 16'h0, gc, gd);
        check_eq("r0_gnt", core_wr_gnt, 1);
        check_eq("r0_we", rf_regWrite, 0);

        // Random traffic; requesters hold until granted.
        pc_v = 0;
        pd_v = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pc_v && ($urandom % 2 == 0)) begin
                pc_v = 1; pc_a = 4'($urandom); pc_d = 16'($urandom);
            end
            if (!pd_v && ($urandom % 3 == 0)) begin
                pd_v = 1; pd_we = 1'($urandom); pd_a = 4'($urandom); pd_d = 16'($urandom);
            end
            run_cycle(pc_v, pc_a, pc_d, pd_v, pd_we, pd_a, pd_d, gc, gd);
            if (gc) pc_v = 0;
            if (gd) pd_v = 0;
        end

        // Reset in the middle of a debug read.
        run_cycle(0, 4'd0, 16'h0, 1, 0, 4'd3, 16'h0, gc, gd);
        @(posedge clk);
        #2;
        check_eq("pre_rst_rvalid", dbg_rvalid, 1);
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_rvalid", dbg_rvalid, 0);
        check_eq("mid_rst_rdata", dbg_rdata, 0);
        check_eq("mid_rst_busy", init_busy, 1);
        repeat (2) @(negedge clk);
        init_phase(99);

        // Pointer must be back to favouring the core.
        run_cycle(1, 4'd9, 16'h9999, 1, 1, 4'd10, 16'hAAAA, gc, gd);
        check_eq("ptr_rst_core", core_wr_gnt, 1);
        for (int c = 0; c < 60; c++) begin
            run_cycle(1'($urandom), 4'($urandom), 16'($urandom),
                      1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom), gc, gd);
        end
        run_cycle(0, 4'd0, 16'h0, 0, 0, 4'd0, 16'h0, gc, gd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
